// File: rtl/switch_reader.sv
// -----------------------------------------------------------------------------
// switch_reader
//
// Reads WIDTH raw DIP switch / button pins. Each pin passes through its own
// synchronizer, and the synchronized vector is then debounced as one unit.
// The block presents:
//   - a clean registered switch value,
//   - one-cycle rise and fall masks,
//   - a valid/ready change event for the consuming logic.
// It runs in the 48 MHz HSOSC clock domain.
//
// Parameters
//   WIDTH            number of switch inputs
//   SYNC_STAGES      synchronizer flops per bit (>= 2)
//   DEBOUNCE_CYCLES  consecutive identical synchronized samples needed to
//                    accept a new vector (>= 1)
//
// Ports
//   clk        in   system clock (HSOSC)
//   reset      in   asynchronous, active-high reset
//   s          in   raw asynchronous switch pins [WIDTH]
//   s_db       out  debounced switch vector [WIDTH]
//   rose       out  one-cycle pulse per bit that went 0->1 in s_db [WIDTH]
//   fell       out  one-cycle pulse per bit that went 1->0 in s_db [WIDTH]
//   evt_valid  out  a debounced change is pending
//   evt_data   out  s_db value captured at the pending change [WIDTH]
//   evt_ready  in   consumer accepts the event
//   overrun    out  sticky: a pending event was overwritten before acceptance
//
// Build option
//   SWITCH_READER_OVERRUN_EN  When this macro is defined, overrun is a sticky
//                             register. When it is undefined, overrun is tied
//                             to 0.
// -----------------------------------------------------------------------------
module switch_reader #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_db,
  output logic [WIDTH-1:0] rose,
  output logic [WIDTH-1:0] fell,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_data,
  input  logic             evt_ready,
  output logic             overrun
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_SETTLE = 1'b1;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Synchronizer: stage 0 samples the pins. The last stage is s_sync.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_s_sync;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_cand;
  logic [CW-1:0]    r_count;

  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] w_cand_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_accept;
  logic [WIDTH-1:0] w_accept_val;

  assign w_s_sync = r_sync[SYNC_STAGES-1];

  // NOTE: the synchronizer flops are cleared by reset like every other state
  // element, so a reset mid-bounce cannot leave stale pin history behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage capture the value
      // from before the edge. That is what makes this a shift chain rather
      // than a single flop.
      r_sync <= {r_sync[SYNC_STAGES-2:0], s};
    end
  end

  // Debounce next-state logic.
  // r_count holds the length of the current run of identical samples equal
  // to r_cand. An acceptance happens on the DEBOUNCE_CYCLES-th sample.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // infer a latch.
    w_state_nxt  = r_state;
    w_cand_nxt   = r_cand;
    w_count_nxt  = r_count;
    w_accept     = 1'b0;
    w_accept_val = r_cand;

    case (r_state)
      ST_STABLE: begin
        w_count_nxt = '0;
        if (w_s_sync != s_db) begin
          w_cand_nxt = w_s_sync;
          if (DEBOUNCE_CYCLES == 1) begin
            w_accept     = 1'b1;
            w_accept_val = w_s_sync;
          end else begin
            w_count_nxt = CNT_ONE;
            w_state_nxt = ST_SETTLE;
          end
        end
      end

      default: begin  // ST_SETTLE
        if (w_s_sync == s_db) begin
          // The input bounced back to the accepted value, so drop the
          // candidate without raising an event.
          w_count_nxt = '0;
          w_state_nxt = ST_STABLE;
        end else if (w_s_sync != r_cand) begin
          // Any bit moved, including a partial multi-bit change.
          // Restart the run with the new value as the candidate.
          w_cand_nxt  = w_s_sync;
          w_count_nxt = CNT_ONE;
        end else if (r_count == CNT_LAST) begin
          w_accept     = 1'b1;
          w_accept_val = r_cand;
          w_count_nxt  = '0;
          w_state_nxt  = ST_STABLE;
        end else begin
          w_count_nxt = r_count + CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_STABLE;
      r_cand    <= '0;
      r_count   <= '0;
      s_db      <= '0;
      rose      <= '0;
      fell      <= '0;
      evt_valid <= 1'b0;
      evt_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_count <= w_count_nxt;

      // rose and fell are pulses, so they return to zero unless an
      // acceptance happens on this edge.
      rose <= '0;
      fell <= '0;
      if (w_accept) begin
        s_db <= w_accept_val;
        rose <= w_accept_val & ~s_db;
        fell <= ~w_accept_val & s_db;
      end

      // A new acceptance has priority over a handshake. The newest value
      // always wins, and valid stays high.
      if (w_accept) begin
        evt_valid <= 1'b1;
        evt_data  <= w_accept_val;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

`ifdef SWITCH_READER_OVERRUN_EN
  logic r_overrun;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_accept && evt_valid && !evt_ready) begin
      r_overrun <= 1'b1;
    end else if (evt_valid && evt_ready && !w_accept) begin
      r_overrun <= 1'b0;
    end
  end

  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_switch_reader.sv
// -----------------------------------------------------------------------------
// tb_switch_reader
//
// Self-checking bench for switch_reader with WIDTH=4, SYNC_STAGES=2 and
// DEBOUNCE_CYCLES=8.
//
// Inputs are driven on the falling edge. The reference model advances on the
// rising edge, and the DUT outputs are compared 1 time unit later.
//
// The reference model describes behaviour at the level of input values:
//   - The synchronizer is a plain delay line.
//   - The debouncer accepts a new value once the last DEBOUNCE_CYCLES
//     delayed samples are all equal and differ from the current debounced
//     value.
// -----------------------------------------------------------------------------
module tb_switch_reader;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DC = 8;

`ifdef SWITCH_READER_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] s;
  logic [W-1:0] s_db;
  logic [W-1:0] rose;
  logic [W-1:0] fell;
  logic         evt_valid;
  logic [W-1:0] evt_data;
  logic         evt_ready;
  logic         overrun;

  always #5 clk = ~clk;

  switch_reader #(
    .WIDTH          (W),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .s_db     (s_db),
    .rose     (rose),
    .fell     (fell),
    .evt_valid(evt_valid),
    .evt_data (evt_data),
    .evt_ready(evt_ready),
    .overrun  (overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] sq[$];    // synchronizer delay line
  logic [W-1:0] hist[$];  // last DC synchronized samples
  logic [W-1:0] m_db, m_rose, m_fell, m_data;
  logic         m_valid, m_ovr;

  task automatic model_reset();
    sq = {};
    for (int i = 0; i < SS; i++) sq.push_back('0);
    hist    = {};
    m_db    = '0;
    m_rose  = '0;
    m_fell  = '0;
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_step(input logic [W-1:0] s_in, input logic rdy);
    logic [W-1:0] x;
    logic         run_ok;
    logic         acc;
    x = sq.pop_front();
    sq.push_back(s_in);
    hist.push_back(x);
    if (hist.size() > DC) void'(hist.pop_front());
    run_ok = (hist.size() == DC);
    foreach (hist[i]) if (hist[i] != x) run_ok = 1'b0;
    acc = run_ok && (x != m_db);

    m_rose = '0;
    m_fell = '0;
    if (acc) begin
      m_rose = x & ~m_db;
      m_fell = ~x & m_db;
      m_db   = x;
    end
    if (OVR_EN) begin
      if (acc && m_valid && !rdy) m_ovr = 1'b1;
      else if (m_valid && rdy && !acc) m_ovr = 1'b0;
    end
    if (acc) begin
      m_valid = 1'b1;
      m_data  = x;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all();
    check("s_db", s_db, m_db);
    check("rose", rose, m_rose);
    check("fell", fell, m_fell);
    check("evt_valid", evt_valid, m_valid);
    check("evt_data", evt_data, m_data);
    check("overrun", overrun, m_ovr);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic [W-1:0] ns, input logic nr);
    s         = ns;
    evt_ready = nr;
    @(posedge clk);
    model_step(ns, nr);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic hold(input logic [W-1:0] ns, input logic nr, input int n);
    for (int i = 0; i < n; i++) cycle(ns, nr);
  endtask

  int lat;
  int vcnt;
  logic [W-1:0] seen_rose, seen_fell;

  initial begin
    s         = '0;
    evt_ready = 1'b0;
    reset     = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    hold(4'b0000, 1'b0, 4);

    // Bounce rejection on bit 2: toggle every 3 cycles, then return.
    for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 4'b0100 : 4'b0000, 1'b0, 3);
    hold(4'b0000, 1'b0, 12);
    check("bounce_db", s_db, 4'b0000);
    check("bounce_valid", evt_valid, 1'b0);
    hold(4'b0100, 1'b0, 12);
    check("bit2_valid", evt_valid, 1'b1);
    check("bit2_data", evt_data, 4'b0100);
    cycle(4'b0100, 1'b1);
    cycle(4'b0100, 1'b0);
    check("bit2_cleared", evt_valid, 1'b0);

    // Clean step 0000 -> 0101 with the latency measured.
    hold(4'b0000, 1'b1, 12);
    lat       = -1;
    seen_rose = '0;
    seen_fell = '1;
    for (int k = 0; k < 20; k++) begin
      cycle(4'b0101, 1'b0);
      if (lat < 0 && s_db == 4'b0101) begin
        lat       = k;
        seen_rose = rose;
        seen_fell = fell;
      end
    end
    check("step_latency", lat, SS + DC - 1);
    check("step_rose", seen_rose, 4'b0101);
    check("step_fell", seen_fell, 4'b0000);
    check("step_valid_held", evt_valid, 1'b1);
    check("step_data_held", evt_data, 4'b0101);

    // Fall with the consumer always ready.
    cycle(4'b0101, 1'b1);
    vcnt      = 0;
    seen_fell = '0;
    for (int k = 0; k < 15; k++) begin
      cycle(4'b0001, 1'b1);
      if (evt_valid) vcnt++;
      seen_fell |= fell;
    end
    check("fall_pulse", seen_fell, 4'b0100);
    check("fall_valid_cycles", vcnt, 1);

    // Overrun: two acceptances without a handshake.
    hold(4'b0000, 1'b0, 12);
    hold(4'b0011, 1'b0, 12);
    check("ovr_data", evt_data, 4'b0011);
    check("ovr_valid", evt_valid, 1'b1);
    check("ovr_flag", overrun, OVR_EN);
    cycle(4'b0011, 1'b1);
    cycle(4'b0011, 1'b0);
    check("ovr_clr_valid", evt_valid, 1'b0);
    check("ovr_clr_flag", overrun, 1'b0);

    // Acceptance on the same edge as a handshake.
    hold(4'b0000, 1'b0, 12);
    hold(4'b1000, 1'b0, SS + DC - 1);
    cycle(4'b1000, 1'b1);
    check("sim_rose", rose, 4'b1000);
    check("sim_valid", evt_valid, 1'b1);
    check("sim_data", evt_data, 4'b1000);
    check("sim_ovr", overrun, 1'b0);
    cycle(4'b1000, 1'b1);

    // Randomized bouncing input and consumer.
    for (int seg = 0; seg < 70; seg++) begin
      logic [W-1:0] ns;
      int len;
      ns  = W'($urandom_range(0, 15));
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) cycle(ns, ($urandom_range(0, 3) == 0));
    end

    // Mid-run asynchronous reset while a candidate is settling.
    hold(4'b1111, 1'b0, 12);
    hold(4'b0000, 1'b0, 4);
    reset = 1'b1;
    #1;
    check("rst_s_db", s_db, 4'b0000);
    check("rst_rose", rose, 4'b0000);
    check("rst_fell", fell, 4'b0000);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_data", evt_data, 4'b0000);
    check("rst_ovr", overrun, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    hold(4'b0000, 1'b0, 15);
    check("post_rst_valid", evt_valid, 1'b0);
    check("post_rst_db", s_db, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
